// File: rtl/uart_tx_fsm_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm_if
// Bundles the signals shared by the UART transmit controller, the upstream
// byte source and the 8-bit serializer.
//
// Handshake: a byte is offered by holding DATA_VALID=1 with P_DATA stable.
// It is taken on the rising CLK edge where SER_LOAD=1. SER_LOAD is high only
// while the controller is in IDLE or STOP. A request seen in any other state
// is dropped, not queued. The source must therefore keep DATA_VALID asserted
// until it sees SER_LOAD=1 at an edge.
//
// Modports:
//   master - byte source plus serializer side: drives P_DATA, DATA_VALID,
//            SER_DATA, SER_DONE (and PAR_EN/PAR_TYP when parity is built in)
//   slave  - the transmit controller: drives SER_LOAD, SER_EN, TX_OUT, BUSY
//
// Build option: UART_TX_PARITY_EN adds the PAR_EN and PAR_TYP signals.
// ---------------------------------------------------------------------------
interface uart_tx_fsm_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             SER_DATA;
  logic             SER_DONE;
`ifdef UART_TX_PARITY_EN
  logic             PAR_EN;
  logic             PAR_TYP;
`endif
  logic             SER_LOAD;
  logic             SER_EN;
  logic             TX_OUT;
  logic             BUSY;

`ifdef UART_TX_PARITY_EN
  modport master (
    output P_DATA, DATA_VALID, SER_DATA, SER_DONE, PAR_EN, PAR_TYP,
    input  SER_LOAD, SER_EN, TX_OUT, BUSY
  );
  modport slave (
    input  P_DATA, DATA_VALID, SER_DATA, SER_DONE, PAR_EN, PAR_TYP,
    output SER_LOAD, SER_EN, TX_OUT, BUSY
  );
`else
  modport master (
    output P_DATA, DATA_VALID, SER_DATA, SER_DONE,
    input  SER_LOAD, SER_EN, TX_OUT, BUSY
  );
  modport slave (
    input  P_DATA, DATA_VALID, SER_DATA, SER_DONE,
    output SER_LOAD, SER_EN, TX_OUT, BUSY
  );
`endif
endinterface

// File: rtl/uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm
// Transmit-side UART controller. It sequences an external 8-bit serializer
// and drives the serial line with start, data, optional parity and stop
// bits. One bit is sent per CLK cycle. Baud pacing is done upstream.
//
// Ports:
//   CLK          - clock, rising edge
//   RST          - synchronous active-high reset
//   bus          - uart_tx_fsm_if slave modport:
//                    P_DATA, DATA_VALID, SER_DATA, SER_DONE, [PAR_EN, PAR_TYP]
//                    in; SER_LOAD, SER_EN, TX_OUT, BUSY out
//   o_dbg_state  - current state encoding, for debug and observation
//
// Build option: UART_TX_PARITY_EN compiles in the parity latch, the parity
// enable/type inputs and the PARITY state. Without it every frame is
// 10 bits long.
// ---------------------------------------------------------------------------
module uart_tx_fsm #(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_fsm_if.slave      bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_par_flag;   // frame carries a parity bit
  logic   w_par_bit;    // parity bit value for the current frame

`ifdef UART_TX_PARITY_EN
  logic r_par_bit;
  logic r_par_flag;

  // Parity is computed from P_DATA at acceptance time. The serializer holds
  // its own copy of the byte, so P_DATA may change during the frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_bit  <= 1'b0;
      r_par_flag <= 1'b0;
    end else if (w_accept) begin
      r_par_bit  <= (^bus.P_DATA) ^ bus.PAR_TYP;
      r_par_flag <= bus.PAR_EN;
    end
  end

  assign w_par_bit  = r_par_bit;
  assign w_par_flag = r_par_flag;
`else
  assign w_par_bit  = 1'b0;
  assign w_par_flag = 1'b0;
`endif

  // A new byte is taken only between frames. Taking it in STOP chains
  // frames back to back with no idle bit.
  assign w_accept = bus.DATA_VALID & ((r_state == IDLE) | (r_state == STOP));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = IDLE;
    bus.SER_LOAD = w_accept;
    bus.SER_EN   = 1'b0;
    bus.TX_OUT   = 1'b1;
    bus.BUSY     = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        w_next = w_accept ? START : IDLE;
      end
      START: begin
        bus.TX_OUT = 1'b0;
        w_next     = DATA;
      end
      DATA: begin
        bus.SER_EN = 1'b1;
        bus.TX_OUT = bus.SER_DATA;
        if (bus.SER_DONE) begin
          w_next = w_par_flag ? PARITY : STOP;
        end else begin
          w_next = DATA;
        end
      end
      PARITY: begin
        bus.TX_OUT = w_par_bit;
        w_next     = STOP;
      end
      STOP: begin
        w_next = w_accept ? START : IDLE;
      end
      default: begin
        // Unused encodings fall back to IDLE on the next edge.
        w_next = IDLE;
      end
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Transmit-side controller for the UART. It sequences the 8-bit serializer and drives the serial line, producing start, data, optional parity, and stop bits. It sits between the upstream byte source and the TX pin, and owns the serializer's load and shift enables plus the output bit-select multiplexer. One bit is sent per `CLK` cycle; baud pacing is applied upstream through the clock or clock-enable domain.

## Interface
- `WIDTH`, 8, data word width. Must match the serializer width.
- `CLK` input 1: single clock. All logic is on its rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `P_DATA` input `WIDTH`: parallel byte. Used here only for parity.
- `DATA_VALID` input 1: upstream request to send `P_DATA`.
- `SER_DATA` input 1: current LSB from the serializer.
- `SER_DONE` input 1: serializer reports its last data bit.
- `PAR_EN` input 1: enables the parity bit. Present only with `UART_TX_PARITY_EN`.
- `PAR_TYP` input 1: parity type, 0 = even, 1 = odd. Present only with `UART_TX_PARITY_EN`.
- `SER_LOAD` output 1: load strobe to the serializer's `Data_Valid`.
- `SER_EN` output 1: shift/count enable to the serializer.
- `TX_OUT` output 1: serial line.
- `BUSY` output 1: a frame is in progress.

## Operation
- **States:** `IDLE`, `START`, `DATA`, `PARITY`, `STOP`. The state register is binary-encoded.
- **Accept rule:** a request is accepted when `DATA_VALID`=1 and the state is `IDLE` or `STOP`. On acceptance:
  - `SER_LOAD`=1 for that cycle.
  - The next state is `START`.
  - The parity bit is latched as `^P_DATA ^ PAR_TYP`.
  - `PAR_EN` is latched into the frame-parity flag.
- **Ignored requests:** `DATA_VALID` in `START`, `DATA` or `PARITY` is ignored. `SER_LOAD` stays 0, so the serializer contents are protected.
- **Combinational `SER_LOAD`:** `SER_LOAD` = `DATA_VALID` & (state==`IDLE` | state==`STOP`).
- **Transitions:**
  - `START` → `DATA` unconditionally.
  - `DATA` → `PARITY` when `SER_DONE`=1 and the latched parity flag is 1.
  - `DATA` → `STOP` when `SER_DONE`=1 and the latched parity flag is 0.
  - `PARITY` → `STOP`.
  - `STOP` → `START` if a request is accepted, otherwise `STOP` → `IDLE`.
- **`SER_EN`:** 1 only in `DATA`. The serializer counter clears whenever `SER_EN`=0, so every frame starts counting from 0.
- **`TX_OUT` mux:**
  - `IDLE` → 1
  - `START` → 0
  - `DATA` → `SER_DATA`
  - `PARITY` → latched parity bit
  - `STOP` → 1
- **`BUSY`:** 1 whenever state ≠ `IDLE`.
- **Unreachable encodings:** recover to `IDLE` on the next cycle.

## Timing
- **Reset:** `RST`=1 at an edge forces state `IDLE`, clears the parity latch and the parity flag.
  - Outputs from the next cycle: `TX_OUT`=1, `BUSY`=0, `SER_EN`=0. `SER_LOAD` follows its equation.
  - Reset mid-frame aborts the frame immediately. The line returns to 1.
- **Acceptance latency:** if the request is accepted at edge n, the start bit appears in cycle n+1.
- **Data bits:** 8 cycles, LSB first. `SER_DONE` is high during the 8th data cycle.
- **Frame length:** 10 cycles without parity, 11 with parity.
- **Back-to-back frames:** a request accepted during `STOP` gives a continuous stream with no idle cycle. Throughput is one frame per 10 or 11 cycles.
- **`SER_DONE` outside `DATA`:** ignored.
- **Simultaneous events:** `RST` and `DATA_VALID` together means reset wins and nothing is accepted. `SER_LOAD` still follows its combinational equation for that cycle; reset does not gate it.
- **Output paths:** `TX_OUT` and `SER_EN` are combinational from registered state plus the registered `SER_DATA`. There is no path from `DATA_VALID` to `TX_OUT`.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - The `PAR_EN` and `PAR_TYP` ports, the parity latch and the `PARITY` state are compiled in.
  - Frame length is 11 cycles when the latched `PAR_EN`=1.
- **`UART_TX_PARITY_EN` undefined:**
  - The ports and the parity logic are absent. The parity flag is tied to 0.
  - `PARITY` is unreachable. Every frame is 10 cycles.

## Test plan
- **Reset:** assert `RST` for 2 cycles, then release with no request → `TX_OUT`=1, `BUSY`=0, `SER_EN`=0 held.
- **Frame without parity:** `P_DATA`=0xA5, `DATA_VALID` pulse in `IDLE` → `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles. `SER_EN`=1 for exactly 8 cycles, `BUSY` for 10, then `IDLE`.
- **Parity:** macro defined, `PAR_EN`=1, 0xA5:
  - `PAR_TYP`=0 → parity bit 0 in cycle 10, stop bit in cycle 11.
  - `PAR_TYP`=1 → parity bit 1.
- **Back-to-back:** 0x0F accepted, then 0xF0 with `DATA_VALID` held during `STOP` → second start bit in the cycle immediately after the first stop bit. 20 contiguous cycles, no idle cycle.
- **Ignored request:** a `DATA_VALID` pulse with 0xFF during the 4th data bit of 0x00 → `SER_LOAD` stays 0 and the frame transmits 0x00 unchanged.
- **Mid-frame reset:** `RST` pulse during the 5th data bit → `TX_OUT`=1 and `BUSY`=0 in the next cycle. A following request for 0x3C transmits correctly.
